// File: rtl/fm_radio_pkg.sv
// rtl/fm_radio_pkg.sv - shared FM radio audio constants and sample types
package fm_radio_pkg;

  localparam int AUDIO_W  = 16;
  localparam int I2S_SLOT = 32;

  typedef struct packed {
    logic [AUDIO_W-1:0] left;
    logic [AUDIO_W-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_transmitter_if.sv
// rtl/i2s_transmitter_if.sv - stereo pair handshake plus I2S serial outputs
interface i2s_transmitter_if #(
  parameter int W = fm_radio_pkg::AUDIO_W
);

  logic [W-1:0] left;
  logic [W-1:0] right;
  logic         valid;
  logic         ready;
  logic         ws;
  logic         sd;
  logic         frame;
  logic         underrun;

  modport master (
    output left, right, valid,
    input  ready, ws, sd, frame, underrun
  );

  modport slave (
    input  left, right, valid,
    output ready, ws, sd, frame, underrun
  );

endinterface

// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - one-pair buffered I2S serializer in the bit-clock domain
module i2s_transmitter
  import fm_radio_pkg::*;
#(
  parameter int W = AUDIO_W,
  parameter int F = I2S_SLOT
) (
  input logic              clk_o,
  input logic              reset,
  i2s_transmitter_if.slave bus
);

  localparam int              CW     = $clog2(2 * F);
  localparam logic [CW-1:0]   K_LAST = CW'(2 * F - 1);
  localparam logic [CW:0]     P_F    = (CW + 1)'(F);
  localparam logic [CW:0]     P_W    = (CW + 1)'(W);
  localparam logic [CW:0]     P_R_LO = (CW + 1)'(F + 1);
  localparam logic [CW:0]     P_R_HI = (CW + 1)'(F + W);

  logic [CW-1:0] k;
  logic [CW:0]   pos;
  logic          load;
  logic          in_left;
  logic          in_right;
  logic          ws_next;

  logic          full;
  logic [W-1:0]  buf_l;
  logic [W-1:0]  buf_r;
  logic [W-1:0]  sh_l;
  logic [W-1:0]  sh_r;

  logic          ws_q;
  logic          sd_q;
  logic          frame_q;
  logic          underrun_q;

  // pos is the index of the cycle being entered, unwrapped: the load edge
  // shows up as 2F, so a right window ending at F+W=2F still spills onto k=0.
  assign load     = (k == K_LAST);
  assign pos      = {1'b0, k} + (CW + 1)'(1);
  assign in_left  = (pos <= P_W);
  assign in_right = (pos >= P_R_LO) && (pos <= P_R_HI);
  assign ws_next  = (pos >= P_F) && !load;

  always_ff @(posedge clk_o or posedge reset) begin
    if (reset) begin
      k <= K_LAST;
    end else if (load) begin
      k <= '0;
    end else begin
      k <= k + CW'(1);
    end
  end

  always_ff @(posedge clk_o or posedge reset) begin
    if (reset) begin
      full  <= 1'b0;
      buf_l <= '0;
      buf_r <= '0;
    end else if (load) begin
      full <= 1'b0;
    end else if (bus.valid && !full) begin
      buf_l <= bus.left;
      buf_r <= bus.right;
      full  <= 1'b1;
    end
  end

  // A load with an empty buffer but valid inputs takes the pair directly.
  always_ff @(posedge clk_o or posedge reset) begin
    if (reset) begin
      sh_l <= '0;
      sh_r <= '0;
    end else if (load) begin
      if (full) begin
        sh_l <= buf_l;
        sh_r <= buf_r;
      end else if (bus.valid) begin
        sh_l <= bus.left;
        sh_r <= bus.right;
      end else begin
        sh_l <= '0;
        sh_r <= '0;
      end
    end else begin
      if (in_left) begin
        sh_l <= sh_l << 1;
      end
      if (in_right) begin
        sh_r <= sh_r << 1;
      end
    end
  end

  always_ff @(posedge clk_o or posedge reset) begin
    if (reset) begin
      ws_q       <= 1'b1;
      sd_q       <= 1'b0;
      frame_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      ws_q       <= ws_next;
      frame_q    <= load;
      underrun_q <= load && !full && !bus.valid;
      if (in_left) begin
        sd_q <= sh_l[W-1];
      end else if (in_right) begin
        sd_q <= sh_r[W-1];
      end else begin
        sd_q <= 1'b0;
      end
    end
  end

  assign bus.ready    = !full;
  assign bus.ws       = ws_q;
  assign bus.sd       = sd_q;
  assign bus.frame    = frame_q;
  assign bus.underrun = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb/tb_i2s_transmitter.sv - scoreboard bench for i2s_transmitter at F=32 and F=W=16
module tb_i2s_transmitter;
  import fm_radio_pkg::*;

  localparam int W  = AUDIO_W;
  localparam int F0 = I2S_SLOT;
  localparam int F1 = 16;

  logic clk_o = 1'b0;
  logic reset = 1'b1;
  always #5 clk_o = ~clk_o;

  i2s_transmitter_if #(.W(W)) bus0 ();
  i2s_transmitter_if #(.W(W)) bus1 ();

  i2s_transmitter #(.W(W), .F(F0)) dut0 (.clk_o(clk_o), .reset(reset), .bus(bus0));
  i2s_transmitter #(.W(W), .F(F1)) dut1 (.clk_o(clk_o), .reset(reset), .bus(bus1));

  int             fs      [2] = '{F0, F1};
  int             mk      [2];
  bit             mfull   [2];
  stereo_sample_t mbuf    [2];
  bit             prev_r0 [2];
  logic [3:0]     exp_q   [2][$];
  bit             rdy_q   [2][$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic stereo_sample_t rnd_pair();
    stereo_sample_t p;
    p.left  = W'($urandom);
    p.right = W'($urandom);
    return p;
  endfunction

  function automatic logic [3:0] outs(int i);
    if (i == 0) return {bus0.ws, bus0.sd, bus0.frame, bus0.underrun};
    return {bus1.ws, bus1.sd, bus1.frame, bus1.underrun};
  endfunction

  function automatic logic rdy(int i);
    return (i == 0) ? bus0.ready : bus1.ready;
  endfunction

  task automatic drive(int i, bit v, stereo_sample_t p);
    if (i == 0) begin
      bus0.valid = v; bus0.left = p.left; bus0.right = p.right;
    end else begin
      bus1.valid = v; bus1.left = p.left; bus1.right = p.right;
    end
  endtask

  // Whole-frame expectation: slot layout computed directly from the sample pair.
  task automatic push_frame(int i, stereo_sample_t ld, bit und);
    int f = fs[i];
    for (int kk = 0; kk < 2 * f; kk++) begin
      bit s = 1'b0;
      if (kk >= 1 && kk <= W) s = ld.left[W - kk];
      else if (kk >= f + 1 && kk <= f + W) s = ld.right[f + W - kk];
      else if (kk == 0 && f == W) s = prev_r0[i];
      exp_q[i].push_back({kk >= f, s, kk == 0, und && kk == 0});
    end
    prev_r0[i] = ld.right[0];
  endtask

  task automatic model_edge(int i, bit v, stereo_sample_t p);
    if (mk[i] == 2 * fs[i] - 1) begin
      stereo_sample_t ld = '0;
      bit und = 1'b0;
      if (mfull[i]) begin
        ld = mbuf[i];
        mfull[i] = 1'b0;
      end else if (v) ld = p;
      else und = 1'b1;
      push_frame(i, ld, und);
      mk[i] = 0;
    end else begin
      if (v && !mfull[i]) begin
        mbuf[i]  = p;
        mfull[i] = 1'b1;
      end
      mk[i]++;
    end
    rdy_q[i].push_back(!mfull[i]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mk[i] = 2 * fs[i] - 1;
      mfull[i] = 1'b0;
      mbuf[i] = '0;
      prev_r0[i] = 1'b0;
      exp_q[i].delete();
      rdy_q[i].delete();
    end
  endtask

  task automatic apply(bit v0, stereo_sample_t p0, bit v1, stereo_sample_t p1);
    drive(0, v0, p0);
    drive(1, v1, p1);
    if (!reset) begin
      model_edge(0, v0, p0);
      model_edge(1, v1, p1);
    end
  endtask

  task automatic cycle(bit v0, stereo_sample_t p0, bit v1, stereo_sample_t p1);
    @(negedge clk_o);
    apply(v0, p0, v1, p1);
  endtask

  task automatic check_reset(string tag);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (outs(i) !== 4'b1000 || rdy(i) !== 1'b1) begin
        n_bad++;
        $display("FAIL %s inst%0d: ws/sd/frame/underrun=%b ready=%b, required 1000 ready=1",
                 tag, i, outs(i), rdy(i));
      end
    end
  endtask

  task automatic check_inst(int i);
    logic [3:0] e;
    bit er;
    n_cmp++;
    if (exp_q[i].size() == 0 || rdy_q[i].size() == 0) begin
      n_bad++;
      $display("FAIL inst%0d scoreboard: no expectation queued at t=%0t", i, $time);
      return;
    end
    e  = exp_q[i].pop_front();
    er = rdy_q[i].pop_front();
    if (outs(i) !== e) begin
      n_bad++;
      $display("FAIL inst%0d slot t=%0t: ws/sd/frame/underrun=%b, required %b",
               i, $time, outs(i), e);
    end
    n_cmp++;
    if (rdy(i) !== er) begin
      n_bad++;
      $display("FAIL inst%0d ready t=%0t: ready=%b, required %b", i, $time, rdy(i), er);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_o);
      #1;
      if (!reset) begin
        check_inst(0);
        check_inst(1);
      end
    end
  end

  initial begin
    stereo_sample_t z, pa, pb;
    z = '0;
    model_reset();
    drive(0, 1'b0, z);
    drive(1, 1'b0, z);
    #12;
    check_reset("reset_values");

    @(negedge clk_o);
    reset = 1'b0;
    apply(1'b0, z, 1'b0, z);

    // idle: zero frames with underrun on every load
    repeat (140) cycle(1'b0, rnd_pair(), 1'b0, rnd_pair());

    // directed single pair; right=0001 on the F=W instance exercises the spill bit
    pa.left = 16'h8001; pa.right = 16'h7FFE;
    pb.left = 16'h8001; pb.right = 16'h0001;
    cycle(1'b1, pa, 1'b1, pb);
    repeat (140) cycle(1'b0, rnd_pair(), 1'b0, rnd_pair());

    // back-pressure: new pair offered every cycle
    repeat (300) cycle(1'b1, rnd_pair(), 1'b1, rnd_pair());

    // sparse random valid
    repeat (500) cycle($urandom_range(0, 19) == 0, rnd_pair(),
                       $urandom_range(0, 19) == 0, rnd_pair());

    // bypass: valid only in the load cycle with an empty buffer
    repeat (300) cycle(mk[0] == 2 * F0 - 1 && !mfull[0], rnd_pair(),
                       mk[1] == 2 * F1 - 1 && !mfull[1], rnd_pair());

    // fill the buffer, then reset at k=20
    repeat (40) cycle(1'b1, rnd_pair(), 1'b1, rnd_pair());
    for (int n = 0; n < 2 * F0 && mk[0] != 20; n++) cycle(1'b1, rnd_pair(), 1'b1, rnd_pair());
    @(negedge clk_o);
    reset = 1'b1;
    #1;
    check_reset("reset_midframe");
    model_reset();
    repeat (2) @(negedge clk_o);
    reset = 1'b0;
    apply(1'b0, z, 1'b0, z);
    repeat (140) cycle(1'b0, rnd_pair(), 1'b0, rnd_pair());

    @(negedge clk_o);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
